tt_tie_bank: RTL and testbench
==============================

TT_TIE_BANK -- requirements
Module: tt_tie_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of driven constant bits, legal range 1..32.
REQ-002 SHALL have parameter DEFAULT, default 0: WIDTH-bit value driven on val after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load_start, input, 1 bit: one-cycle request to begin a serial load.
REQ-006 SHALL have port sin, input, 1 bit: serial data bit, MSB first.
REQ-007 SHALL have port sin_valid, input, 1 bit: sin is sampled in the cycles this is high.
REQ-008 SHALL have port val, output, WIDTH bits: registered constant outputs.
REQ-009 SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a new value is committed to val.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and COMMIT.
REQ-012 SHALL, in IDLE with load_start=1, clear the bit counter, enter SHIFT and assert busy from the next cycle.
REQ-013 SHALL, in SHIFT, shift sin into a shadow register and increment a ceil(log2(WIDTH+1))-bit counter on every cycle with sin_valid=1.
REQ-014 SHALL ignore cycles with sin_valid=0 in SHIFT: shadow and counter hold, with no timeout.
REQ-015 SHALL enter COMMIT on the cycle the counter reaches WIDTH.
REQ-016 SHALL, in COMMIT, copy shadow to val, pulse done for exactly that cycle, deassert busy and return to IDLE.
REQ-017 SHALL make the latency from the last accepted bit to the val update exactly 1 cycle.
REQ-018 SHALL keep val unchanged in all states except COMMIT, so a partial load never glitches outputs.
REQ-019 SHALL, on load_start=1 during SHIFT, restart the load: clear counter and shadow, stay in SHIFT, and discard the bits of that cycle.
REQ-020 SHALL, on load_start=1 during COMMIT, complete the commit and then start a new load, entering SHIFT next cycle.
REQ-021 SHALL ignore sin_valid in IDLE and COMMIT.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set val=DEFAULT, busy=0, done=0, counter=0, shadow=0 and state=IDLE.
REQ-023 SHALL give rst priority over every other input, including mid-SHIFT; a reset mid-load drops the partial value.

Configuration
REQ-024 SHALL, with macro TT_TIE_BANK_LOCK_EN defined, add input port lock (1 bit).
REQ-025 SHALL, with TT_TIE_BANK_LOCK_EN, set an internal sticky lock flag when lock=1 in IDLE; the flag clears only on rst.
REQ-026 SHALL, while the lock flag is set, ignore load_start; a lock asserted during SHIFT takes effect once the FSM returns to IDLE.
REQ-027 SHALL, without TT_TIE_BANK_LOCK_EN, have no lock port and no lock flag, and behave as REQ-011..REQ-021.

Structure
REQ-028 SHALL take the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2) and a counter-width function from shared package tt_tie_pkg.
REQ-029 SHALL place the shadow shift register and bit counter in sub-module tt_tie_bank_shreg, with the FSM and val register in the top level.
REQ-030 SHALL contain no vendor cell instances; constant-driving primitives stay in the prim library.

Verification
REQ-031 SHALL cover: reset with WIDTH=8, DEFAULT=8'hA5 -> val=8'hA5, busy=0, done=0.
REQ-032 SHALL cover: load_start, then 8 consecutive valid bits 1,0,1,1,0,0,1,0 -> val=8'hB2 one cycle after the 8th bit, done high exactly one cycle.
REQ-033 SHALL cover: load with sin_valid gaps of 3 cycles between bits -> same final val as REQ-032, val held at its old value throughout.
REQ-034 SHALL cover: load_start after 5 bits, then a full 8-bit load of 8'h3C -> val=8'h3C, no done pulse before it.
REQ-035 SHALL cover: rst after 4 of 8 bits -> val=DEFAULT, state IDLE, and following sin_valid pulses do not change val.
REQ-036 SHALL cover, with TT_TIE_BANK_LOCK_EN: lock in IDLE, then a full load of 8'hFF -> val unchanged, busy stays 0; after rst a load succeeds.

Source files
------------

// File: rtl/tt_tie_pkg.sv
// Shared FSM encoding and counter sizing for the tt_tie_bank constant-driver bank.
package tt_tie_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } tt_state_e;

   // ceil(log2(w+1)): enough bits to count 0..w inclusive, minimum 1.
   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned n;
      n = 1;
      while ((32'd1 << n) < (w + 32'd1)) n = n + 1;
      return n;
   endfunction

endpackage

// File: rtl/tt_tie_bank_shreg.sv
// Shadow shift register (MSB first) and accepted-bit counter for tt_tie_bank.
module tt_tie_bank_shreg
   import tt_tie_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             shift_en_i,
   input  logic             sin_i,
   output logic [WIDTH-1:0] shadow_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   shifted;

   // Widened concat keeps the shift legal for WIDTH=1.
   assign shifted = {shadow_q, sin_i};

   always_comb begin
      shadow_d = shadow_q;
      count_d  = count_q;
      if (clr_i) begin
         shadow_d = '0;
         count_d  = '0;
      end else if (shift_en_i) begin
         shadow_d = shifted[WIDTH-1:0];
         count_d  = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         count_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         count_q  <= count_d;
      end
   end

   assign shadow_o = shadow_q;
   assign count_o  = count_q;

endmodule

// File: rtl/tt_tie_bank.sv
// Serially loadable bank of registered constant outputs; val changes only on commit.
// Optional TT_TIE_BANK_LOCK_EN adds a sticky lock input that blocks further loads until reset.
module tt_tie_bank
   import tt_tie_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] DEFAULT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             sin,
   input  logic             sin_valid,
`ifdef TT_TIE_BANK_LOCK_EN
   input  logic             lock,
`endif
   output logic [WIDTH-1:0] val,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = cnt_width(WIDTH);

   tt_state_e        state_q;
   logic [WIDTH-1:0] val_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] shadow;
   logic [CW-1:0]    bit_cnt;
   logic             start_ok;
   logic             sh_clr;
   logic             sh_en;
   logic             last_bit;

`ifdef TT_TIE_BANK_LOCK_EN
   logic lock_q;
   assign start_ok = load_start & ~lock_q;
`else
   assign start_ok = load_start;
`endif

   // A restart in SHIFT clears the shadow and discards that cycle's bit.
   always_comb begin
      sh_clr = 1'b0;
      sh_en  = 1'b0;
      case (state_q)
         IDLE:   sh_clr = start_ok;
         SHIFT: begin
            sh_clr = start_ok;
            sh_en  = sin_valid & ~start_ok;
         end
         COMMIT: sh_clr = start_ok;
         default: ;
      endcase
   end

   assign last_bit = sh_en && (bit_cnt == CW'(WIDTH - 1));

   tt_tie_bank_shreg #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_shreg (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (sh_clr),
      .shift_en_i (sh_en),
      .sin_i      (sin),
      .shadow_o   (shadow),
      .count_o    (bit_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         val_q   <= DEFAULT;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef TT_TIE_BANK_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
`ifdef TT_TIE_BANK_LOCK_EN
               if (lock) lock_q <= 1'b1;
`endif
               if (start_ok) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end
            end
            SHIFT: begin
               if (last_bit) state_q <= COMMIT;
            end
            COMMIT: begin
               val_q  <= shadow;
               done_q <= 1'b1;
               if (start_ok) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign val  = val_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tt_tie_bank.sv
// Directed bench for tt_tie_bank (WIDTH=8, DEFAULT=8'hA5); lock scenario under TT_TIE_BANK_LOCK_EN.
module tb_tt_tie_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_start = 1'b0;
   logic       sin = 1'b0;
   logic       sin_valid = 1'b0;
   logic       lock = 1'b0;
   logic [7:0] val;
   logic       busy;
   logic       done;

   int vectors = 0;
   int miscompares = 0;
   int glitches = 0;
   int dones = 0;

   tt_tie_bank #(
      .WIDTH   (8),
      .DEFAULT (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .sin        (sin),
      .sin_valid  (sin_valid),
`ifdef TT_TIE_BANK_LOCK_EN
      .lock       (lock),
`endif
      .val        (val),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tally(input logic [7:0] hold);
      if (val !== hold) glitches++;
      if (done !== 1'b0) dones++;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   // Sends v[7], v[6], ... for nbits bits with `gap` invalid cycles before each.
   task automatic send_bits(input logic [7:0] v, input int nbits, input int gap,
                            input logic [7:0] hold);
      logic [7:0] w;
      w = v;
      for (int i = 0; i < nbits; i++) begin
         for (int g = 0; g < gap; g++) begin
            sin_valid = 1'b0;
            sin = 1'($urandom_range(0, 1));
            step();
            tally(hold);
         end
         sin = w[7-i];
         sin_valid = 1'b1;
         step();
         tally(hold);
      end
      sin_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++; if (val !== 8'hA5) begin miscompares++; $display("FAIL reset_val: got %h expected %h", val, 8'hA5); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
   endtask

   task automatic test_load();
      glitches = 0; dones = 0;
      start_load();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b expected 1", busy); end
      send_bits(8'hB2, 8, 0, 8'hA5);
      vectors++; if (glitches != 0) begin miscompares++; $display("FAIL load_hold: got %0d changed cycles expected 0", glitches); end
      vectors++; if (dones != 0) begin miscompares++; $display("FAIL load_early_done: got %0d expected 0", dones); end
      step();
      vectors++; if (val !== 8'hB2) begin miscompares++; $display("FAIL load_val: got %h expected %h", val, 8'hB2); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL load_done: got %b expected 1", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL load_busy_end: got %b expected 0", busy); end
      step();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL load_done_width: got %b expected 0", done); end
      vectors++; if (val !== 8'hB2) begin miscompares++; $display("FAIL load_val_keep: got %h expected %h", val, 8'hB2); end
   endtask

   task automatic test_gaps();
      start_load();
      send_bits(8'h5A, 8, 0, 8'hB2);
      step();
      vectors++; if (val !== 8'h5A) begin miscompares++; $display("FAIL gap_pre_val: got %h expected %h", val, 8'h5A); end
      glitches = 0; dones = 0;
      start_load();
      send_bits(8'hB2, 8, 3, 8'h5A);
      vectors++; if (glitches != 0) begin miscompares++; $display("FAIL gap_hold: got %0d changed cycles expected 0", glitches); end
      vectors++; if (dones != 0) begin miscompares++; $display("FAIL gap_early_done: got %0d expected 0", dones); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy: got %b expected 1", busy); end
      step();
      vectors++; if (val !== 8'hB2) begin miscompares++; $display("FAIL gap_val: got %h expected %h", val, 8'hB2); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL gap_done: got %b expected 1", done); end
   endtask

   task automatic test_restart();
      glitches = 0; dones = 0;
      start_load();
      send_bits(8'hFF, 5, 0, 8'hB2);
      sin = 1'b1;
      sin_valid = 1'b1;
      load_start = 1'b1;
      step();
      tally(8'hB2);
      load_start = 1'b0;
      sin_valid = 1'b0;
      send_bits(8'h3C, 8, 0, 8'hB2);
      vectors++; if (dones != 0) begin miscompares++; $display("FAIL restart_early_done: got %0d expected 0", dones); end
      vectors++; if (glitches != 0) begin miscompares++; $display("FAIL restart_hold: got %0d changed cycles expected 0", glitches); end
      step();
      vectors++; if (val !== 8'h3C) begin miscompares++; $display("FAIL restart_val: got %h expected %h", val, 8'h3C); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL restart_done: got %b expected 1", done); end
   endtask

   task automatic test_reset_mid();
      start_load();
      send_bits(8'hF0, 4, 0, 8'h3C);
      apply_reset();
      vectors++; if (val !== 8'hA5) begin miscompares++; $display("FAIL midrst_val: got %h expected %h", val, 8'hA5); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      glitches = 0; dones = 0;
      send_bits(8'hFF, 8, 1, 8'hA5);
      step();
      tally(8'hA5);
      vectors++; if (glitches != 0) begin miscompares++; $display("FAIL midrst_idle_sin: got %0d changed cycles expected 0", glitches); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      start_load();
      send_bits(8'h81, 8, 0, 8'hA5);
      load_start = 1'b1;
      sin = 1'b1;
      sin_valid = 1'b1;
      step();
      load_start = 1'b0;
      sin_valid = 1'b0;
      vectors++; if (val !== 8'h81) begin miscompares++; $display("FAIL b2b_val1: got %h expected %h", val, 8'h81); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done1: got %b expected 1", done); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      send_bits(8'h7E, 8, 0, 8'h81);
      step();
      vectors++; if (val !== 8'h7E) begin miscompares++; $display("FAIL b2b_val2: got %h expected %h", val, 8'h7E); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done2: got %b expected 1", done); end
   endtask

`ifdef TT_TIE_BANK_LOCK_EN
   task automatic test_lock();
      step();
      lock = 1'b1;
      step();
      lock = 1'b0;
      glitches = 0; dones = 0;
      start_load();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lock_busy: got %b expected 0", busy); end
      send_bits(8'hFF, 8, 0, 8'h7E);
      step();
      tally(8'h7E);
      vectors++; if (glitches != 0) begin miscompares++; $display("FAIL lock_val: got %0d changed cycles expected 0", glitches); end
      vectors++; if (dones != 0) begin miscompares++; $display("FAIL lock_done: got %0d expected 0", dones); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lock_busy_end: got %b expected 0", busy); end
      apply_reset();
      start_load();
      send_bits(8'hFF, 8, 0, 8'hA5);
      step();
      vectors++; if (val !== 8'hFF) begin miscompares++; $display("FAIL unlock_val: got %h expected %h", val, 8'hFF); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL unlock_done: got %b expected 1", done); end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_gaps();
      test_restart();
      test_reset_mid();
      test_back_to_back();
`ifdef TT_TIE_BANK_LOCK_EN
      test_lock();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
